// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter family: FSM state encoding and error counter limit.
package ring_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ACQUIRE = ACQUIRE,
        ST_LOCKED  = LOCKED
    } ring_state_e;

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot to binary index encoder with a one-hot validity flag.
module ring_onehot_decode #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] index_o,
    output logic             onehot_o
);

    // OR of bit positions; only meaningful when onehot_o is set.
    always_comb begin
        index_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                index_o = index_o | IDX_W'(i);
            end
        end
    end

    assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_seq_checker.sv
// Receive-side ring counter checker: decodes, tracks rotation, locks, counts revolutions and errors.
// Optional error counter enabled by defining RING_SEQ_CHECKER_ERR_CNT_EN.
module ring_seq_checker
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         count_in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     err,
    output logic [7:0]               err_cnt,
    output logic [REV_W-1:0]         revs,
    output logic                     rev_pulse
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

    ring_state_e        state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               index_valid_q, index_valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0]   revs_q, revs_d;

    logic [IDX_W-1:0]   dec_index;
    logic               dec_onehot;
    logic [WIDTH-1:0]   prev_rot;
    logic [GOOD_W-1:0]  good_inc;
    logic               step_ok;

    ring_onehot_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .vec_i    (count_in),
        .index_o  (dec_index),
        .onehot_o (dec_onehot)
    );

    assign prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign good_inc = good_q + GOOD_W'(1);
    assign step_ok  = dec_onehot && (count_in == prev_rot);

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        good_d        = good_q;
        index_d       = index_q;
        index_valid_d = index_valid_q;
        revs_d        = revs_q;
        err_d         = 1'b0;
        rev_pulse_d   = 1'b0;
        if (en) begin
            index_valid_d = dec_onehot;
            if (dec_onehot) begin
                index_d = dec_index;
                prev_d  = count_in;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (dec_onehot) begin
                        good_d  = '0;
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (step_ok) begin
                        if (good_inc == GOOD_LOCK) begin
                            good_d  = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_inc;
                        end
                    end else if (dec_onehot) begin
                        good_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (step_ok) begin
                        // Landing on bit 0 completes a revolution.
                        if (count_in == WIDTH'(1)) begin
                            revs_d      = revs_q + REV_W'(1);
                            rev_pulse_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = dec_onehot ? ST_ACQUIRE : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            prev_q        <= '0;
            good_q        <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            rev_pulse_q   <= 1'b0;
            revs_q        <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            good_q        <= good_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            rev_pulse_q   <= rev_pulse_d;
            revs_q        <= revs_d;
        end
    end

`ifdef RING_SEQ_CHECKER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign rev_pulse   = rev_pulse_q;
    assign revs        = revs_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Table-driven scoreboard bench for ring_seq_checker (WIDTH=4, LOCK_CNT=2, REV_W=2).
module tb_ring_seq_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic [1:0]       index;
    logic             index_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_cnt;
    logic [REV_W-1:0] revs;
    logic             rev_pulse;

    ring_seq_checker #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT),
        .REV_W    (REV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_in    (count_in),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .revs        (revs),
        .rev_pulse   (rev_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] cin;
        logic [1:0] idx;
        logic       iv;
        logic       lk;
        logic       er;
        logic       rp;
        logic [1:0] rv;
        int         errs;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ecnt(input int errs);
`ifdef RING_SEQ_CHECKER_ERR_CNT_EN
        return (errs > 255) ? 32'd255 : 32'(errs);
`else
        return 32'd0;
`endif
    endfunction

    task automatic add(input logic e, input logic [3:0] c, input logic [1:0] idx,
                       input logic iv, input logic lk, input logic er, input logic rp,
                       input logic [1:0] rv, input int errs);
        vec_t v;
        v.en = e; v.cin = c; v.idx = idx; v.iv = iv; v.lk = lk;
        v.er = er; v.rp = rp; v.rv = rv; v.errs = errs;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int tag);
        vec_t e;
        @(negedge clk);
        en       = v.en;
        count_in = v.cin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL v%0d.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d.index", tag),       32'(index),       32'(e.idx));
            chk($sformatf("v%0d.index_valid", tag), 32'(index_valid), 32'(e.iv));
            chk($sformatf("v%0d.locked", tag),      32'(locked),      32'(e.lk));
            chk($sformatf("v%0d.err", tag),         32'(err),         32'(e.er));
            chk($sformatf("v%0d.rev_pulse", tag),   32'(rev_pulse),   32'(e.rp));
            chk($sformatf("v%0d.revs", tag),        32'(revs),        32'(e.rv));
            chk($sformatf("v%0d.err_cnt", tag),     32'(err_cnt),     exp_ecnt(e.errs));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".index"},       32'(index),       32'd0);
        chk({tag, ".index_valid"}, 32'(index_valid), 32'd0);
        chk({tag, ".locked"},      32'(locked),      32'd0);
        chk({tag, ".err"},         32'(err),         32'd0);
        chk({tag, ".rev_pulse"},   32'(rev_pulse),   32'd0);
        chk({tag, ".revs"},        32'(revs),        32'd0);
        chk({tag, ".err_cnt"},     32'(err_cnt),     32'd0);
    endtask

    initial begin
        //   en  cin      idx  iv lk er rp revs errs
        add(1, 4'b0011, 2'd0, 0, 0, 0, 0, 2'd0, 0);  // 0  invalid in IDLE
        add(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, 0);  // 1  enter ACQUIRE
        add(1, 4'b0010, 2'd1, 1, 0, 0, 0, 2'd0, 0);  // 2  good=1
        add(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd0, 0);  // 3  lock
        add(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd0, 0);  // 4
        add(1, 4'b0001, 2'd0, 1, 1, 0, 1, 2'd1, 0);  // 5  rev 1
        add(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd1, 0);  // 6
        add(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd1, 0);  // 7
        add(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd1, 0);  // 8
        add(1, 4'b0001, 2'd0, 1, 1, 0, 1, 2'd2, 0);  // 9  rev 2
        add(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd2, 0);  // 10
        add(1, 4'b1000, 2'd3, 1, 0, 1, 0, 2'd2, 1);  // 11 wrong step while locked
        add(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd2, 1);  // 12 no rev in ACQUIRE
        add(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd2, 1);  // 13 relock
        add(1, 4'b0010, 2'd1, 1, 0, 1, 0, 2'd2, 2);  // 14 repeat is an error
        add(1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd2, 2);  // 15
        add(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd2, 2);  // 16 relock
        add(1, 4'b0000, 2'd3, 0, 0, 1, 0, 2'd2, 3);  // 17 all-zero -> IDLE
        add(1, 4'b0110, 2'd3, 0, 0, 0, 0, 2'd2, 3);  // 18 no err in IDLE
        add(0, 4'b1111, 2'd3, 0, 0, 0, 0, 2'd2, 3);  // 19 stalled
        add(1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd2, 3);  // 20 ACQUIRE
        add(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd2, 3);  // 21 wrong step, restart
        add(1, 4'b0010, 2'd1, 1, 0, 0, 0, 2'd2, 3);  // 22
        add(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd2, 3);  // 23 locked at 0100
        add(0, 4'b1111, 2'd2, 1, 1, 0, 0, 2'd2, 3);  // 24 stall x3
        add(0, 4'b1111, 2'd2, 1, 1, 0, 0, 2'd2, 3);  // 25
        add(0, 4'b1111, 2'd2, 1, 1, 0, 0, 2'd2, 3);  // 26
        add(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd2, 3);  // 27
        add(1, 4'b0001, 2'd0, 1, 1, 0, 1, 2'd3, 3);  // 28 rev 3
        add(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd3, 3);  // 29
        add(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd3, 3);  // 30
        add(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd3, 3);  // 31
        add(1, 4'b0001, 2'd0, 1, 1, 0, 1, 2'd0, 3);  // 32 rev 4 wraps to 0

        // Reset held with random traffic: everything stays cleared.
        rst = 1'b0;
        en  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            count_in = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Four more revolutions: revs (2 bits) returns to 0 after eight in total.
        begin
            vec_t v;
            logic [1:0] rv_e;
            rv_e = 2'd0;
            for (int k = 1; k <= 16; k++) begin
                v.en   = 1'b1;
                v.cin  = 4'b0001 << (k % 4);
                v.idx  = 2'(k % 4);
                v.iv   = 1'b1;
                v.lk   = 1'b1;
                v.er   = 1'b0;
                v.rp   = ((k % 4) == 0);
                if ((k % 4) == 0) rv_e = rv_e + 2'd1;
                v.rv   = rv_e;
                v.errs = 3;
                apply(v, 100 + k);
            end
        end

        // Asynchronous reset mid-cycle while locked.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("async_rst_held");
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
